// File: rtl/fifo_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_gen_pkg
// Brief    : Shared types and helper functions for the generic FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_gen_pkg;

  // Operation requested at a clock edge, before qualification by fill level.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } fifo_op_e;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int f_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment with explicit wrap, so any depth works.
  function automatic int f_inc_wrap(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_gen_if
// Brief    : Producer/consumer handshake and status bundle of the generic FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_gen_if #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = fifo_gen_pkg::f_cw(DEPTH);

  logic            push_i;
  logic [BITS-1:0] data_i;
  logic            pop_i;
  logic            clr_err_i;
  logic [BITS-1:0] data_o;
  logic            full_o;
  logic            pnding_o;
  logic            afull_o;
  logic            aempty_o;
  logic [CW-1:0]   count_o;
  logic            ovf_o;
  logic            udf_o;

  // FIFO side.
  modport slave (
    input  push_i, data_i, pop_i, clr_err_i,
    output data_o, full_o, pnding_o, afull_o, aempty_o, count_o, ovf_o, udf_o
  );

  // Producer/consumer side.
  modport master (
    output push_i, data_i, pop_i, clr_err_i,
    input  data_o, full_o, pnding_o, afull_o, aempty_o, count_o, ovf_o, udf_o
  );
endinterface
`default_nettype wire

// File: rtl/fifo_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_gen_ctrl
// Brief    : Pointers, occupancy counter, operation decode, level flags and
//            sticky error flags of the generic FIFO (no storage).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_gen_ctrl
  import fifo_gen_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AF_TH = DEPTH - 1,
  parameter int AE_TH = 1,
  parameter int CW    = f_cw(DEPTH),
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr_err,
  output logic          o_wr_en,
  output logic [PW-1:0] o_wp,
  output logic [PW-1:0] o_rp,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_pnding,
  output logic          o_afull,
  output logic          o_aempty,
  output logic          o_ovf,
  output logic          o_udf
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_af_th = CW'(AF_TH);
  localparam logic [CW-1:0] c_ae_th = CW'(AE_TH);

  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_udf;

  fifo_op_e      w_op;
  logic          w_empty;
  logic          w_full;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_ovf_set;
  logic          w_udf_set;
  logic [PW-1:0] w_wp_nxt;
  logic [PW-1:0] w_rp_nxt;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == c_depth);
  assign w_wp_nxt = PW'(f_inc_wrap(int'(r_wp), DEPTH));
  assign w_rp_nxt = PW'(f_inc_wrap(int'(r_rp), DEPTH));

  // Decode the raw request; reset masks any push or pop in the same cycle.
  always_comb begin
    w_op = OP_IDLE;
    if (!rst_i) begin
      case ({i_push, i_pop})
        2'b10:   w_op = OP_PUSH;
        2'b01:   w_op = OP_POP;
        2'b11:   w_op = OP_BOTH;
        default: w_op = OP_IDLE;
      endcase
    end
  end

  // Qualify the request against the fill level; a full FIFO still accepts a
  // push when a pop frees the slot, an empty one never forwards data.
  always_comb begin
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    case (w_op)
      OP_PUSH: begin
        w_wr_en   = !w_full;
        w_ovf_set = w_full;
      end
      OP_POP: begin
        w_rd_en   = !w_empty;
        w_udf_set = w_empty;
      end
      OP_BOTH: begin
        w_wr_en   = 1'b1;
        w_rd_en   = !w_empty;
        w_udf_set = w_empty;
      end
      default: ;
    endcase
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr_en) r_wp <= w_wp_nxt;
      if (w_rd_en) r_rp <= w_rp_nxt;
      if (w_wr_en && !w_rd_en)      r_cnt <= r_cnt + CW'(1);
      else if (w_rd_en && !w_wr_en) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Sticky error flags; a new event in the clear cycle keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (i_clr_err) r_ovf <= 1'b0;
      if (w_udf_set)      r_udf <= 1'b1;
      else if (i_clr_err) r_udf <= 1'b0;
    end
  end

  assign o_wr_en  = w_wr_en;
  assign o_wp     = r_wp;
  assign o_rp     = r_rp;
  assign o_count  = r_cnt;
  assign o_full   = w_full;
  assign o_pnding = !w_empty;
  assign o_afull  = (r_cnt >= c_af_th);
  assign o_aempty = (r_cnt <= c_ae_th);
  assign o_ovf    = r_ovf;
  assign o_udf    = r_udf;

endmodule
`default_nettype wire

// File: rtl/fifo_gen_top.sv
`default_nettype none
// ============================================================================
// Module   : fifo_gen_top
// Brief    : Parametrised synchronous show-ahead FIFO with occupancy count,
//            programmable almost-full/almost-empty and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_gen_top
  import fifo_gen_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 4,
  parameter int AF_TH = DEPTH - 1,
  parameter int AE_TH = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  fifo_gen_if.slave  bus
);

  localparam int CW = f_cw(DEPTH);
  localparam int PW = $clog2(DEPTH);

  if (BITS < 1) begin : g_chk_bits
    $error("fifo_gen_top: BITS must be >= 1");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("fifo_gen_top: DEPTH must be >= 2");
  end
  if (AF_TH < 1 || AF_TH > DEPTH) begin : g_chk_af_th
    $error("fifo_gen_top: AF_TH must be in 1..DEPTH");
  end
  if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_chk_ae_th
    $error("fifo_gen_top: AE_TH must be in 0..DEPTH-1");
  end

  logic [BITS-1:0] r_mem [DEPTH];

  logic            w_wr_en;
  logic [PW-1:0]   w_wp;
  logic [PW-1:0]   w_rp;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_pnding;
  logic            w_afull;
  logic            w_aempty;
  logic            w_ovf;
  logic            w_udf;

  fifo_gen_ctrl #(
    .DEPTH (DEPTH),
    .AF_TH (AF_TH),
    .AE_TH (AE_TH),
    .CW    (CW),
    .PW    (PW)
  ) u_ctrl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_push    (bus.push_i),
    .i_pop     (bus.pop_i),
    .i_clr_err (bus.clr_err_i),
    .o_wr_en   (w_wr_en),
    .o_wp      (w_wp),
    .o_rp      (w_rp),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_pnding  (w_pnding),
    .o_afull   (w_afull),
    .o_aempty  (w_aempty),
    .o_ovf     (w_ovf),
    .o_udf     (w_udf)
  );

  // Storage write; contents survive reset and are hidden by the output gate.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_wp] <= bus.data_i;
  end

  assign bus.data_o   = w_pnding ? r_mem[w_rp] : '0;
  assign bus.full_o   = w_full;
  assign bus.pnding_o = w_pnding;
  assign bus.afull_o  = w_afull;
  assign bus.aempty_o = w_aempty;
  assign bus.count_o  = w_count;
  assign bus.ovf_o    = w_ovf;
  assign bus.udf_o    = w_udf;

endmodule
`default_nettype wire

// File: doc/fifo_gen_top.md
# fifo_gen_top

Parametrised synchronous FIFO and the successor of the fixed `fifo_top` buffer. It keeps the same push/pop/full/pending handshake. It adds:

- arbitrary (non-power-of-2) depth;
- occupancy count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- defined simultaneous push/pop behaviour at every fill level.

It sits between a producer and a consumer in the same clock domain.

## Interface

- `BITS`, default 32: data word width; legal values ≥1.
- `DEPTH`, default 4: number of entries; legal values ≥2, need not be a power of 2.
- `AF_TH`, default `DEPTH-1`: `afull_o` asserts when count ≥ `AF_TH`; legal range 1..`DEPTH`.
- `AE_TH`, default 1: `aempty_o` asserts when count ≤ `AE_TH`; legal range 0..`DEPTH-1`.

Ports (`CW` = `$clog2(DEPTH+1)`):

- `clk_i` in 1: single clock; all logic is on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `push_i` in 1: write request; `data_i` is captured on a clock edge with `push_i`=1 if accepted.
- `data_i` in `BITS`: write data.
- `pop_i` in 1: read request; removes the head entry.
- `clr_err_i` in 1: synchronous clear of `ovf_o` and `udf_o`.
- `data_o` out `BITS`: head entry (show-ahead); 0 when empty.
- `full_o` out 1: count == `DEPTH`.
- `pnding_o` out 1: count ≠ 0.
- `afull_o` out 1: count ≥ `AF_TH`.
- `aempty_o` out 1: count ≤ `AE_TH`.
- `count_o` out `CW`: current occupancy.
- `ovf_o` out 1: sticky flag; a push was dropped.
- `udf_o` out 1: sticky flag; a pop was issued while empty.

## Operation

- Storage is an array of `DEPTH`×`BITS` registers, with write pointer `wp`, read pointer `rp` and counter `cnt`.
- Pointers wrap from `DEPTH-1` to 0 by explicit compare, not a power-of-2 mask.
- Each edge is decoded from (push_i, pop_i, state):
  - push only, not full: write `mem[wp]`, `wp++`, `cnt++`.
  - push only, full: data dropped, storage unchanged, `ovf_o` set.
  - pop only, not empty: `rp++`, `cnt--`.
  - pop only, empty: no state change, `udf_o` set.
  - push+pop, 0 < cnt < `DEPTH`: write and read both happen; `cnt` unchanged.
  - push+pop, full: both accepted (the pop frees the slot); `cnt` stays `DEPTH`; no overflow.
  - push+pop, empty: push accepted, `cnt` becomes 1; the pop is an underflow and sets `udf_o`. There is no bypass: data never passes through in the same cycle.
- Sticky flags:
  - Set by the events above.
  - Cleared only by `clr_err_i` or `rst_i`.
  - If `clr_err_i` and a set event occur in the same cycle, set wins.
- `data_o` is `mem[rp]` gated by `pnding_o`. It shows the head without a pop.
- All status outputs are decoded from registered `cnt`. Status outputs are not computed from the pointers.

## Timing

- Reset is synchronous: `rst_i`=1 at an edge forces `wp`=`rp`=`cnt`=0 and `ovf_o`=`udf_o`=0. Any push or pop in that cycle is ignored.
- Output values after reset:
  - `count_o`=0, `full_o`=0, `pnding_o`=0, `data_o`=0.
  - `afull_o`=0 when `AF_TH` ≥ 1.
  - `aempty_o`=1.
- Storage contents are not cleared by reset; they are invisible because `data_o` is gated.
- Reset mid-operation (any fill level) empties the FIFO in one cycle; previously stored data is lost.
- Latency:
  - A push at edge N is visible on `data_o`/`pnding_o` after edge N (write-to-read latency 1) when the FIFO was empty.
  - Flags update after the same edge that changes `cnt`.
- Pop semantics: the consumer samples `data_o` in the cycle it asserts `pop_i`; the next entry appears after the edge.
- There is no combinational path from `push_i` or `pop_i` to any output.

## Structure

- Package `fifo_gen_pkg` holds:
  - function `f_cw(depth)` returning `$clog2(depth+1)`;
  - function `f_inc_wrap(ptr, depth)`;
  - enum `fifo_op_e` {`OP_IDLE`, `OP_PUSH`, `OP_POP`, `OP_BOTH`} for the decoded operation.
- Sub-module `fifo_gen_ctrl` contains the pointers, counter, operation decode, flags and sticky errors. `fifo_gen_top` holds the storage array and instantiates `fifo_gen_ctrl`.
- Elaboration-time assertions check the legal ranges of `DEPTH`, `AF_TH` and `AE_TH`.

## Test plan

All scenarios use `BITS`=32, `DEPTH`=4, `AF_TH`=3, `AE_TH`=1 unless stated otherwise.

1. **Fill and drain.** Push 0xA, 0xB, 0xC, 0xD → `count_o` goes 1..4; `afull_o` asserts at 3; `full_o` asserts at 4. Then pop ×4 → `data_o` reads 0xA, 0xB, 0xC, 0xD in order; `pnding_o`=0 and `aempty_o`=1 at the end.
2. **Overflow and underflow.** With the FIFO full, push 0xE → contents unchanged, `ovf_o`=1. Drain, then pop on empty → `udf_o`=1. Assert `clr_err_i` → both flags return to 0.
3. **Simultaneous push/pop.**
   - At count 2: push 0x10 + pop → count stays 2.
   - At count 4: push 0x11 + pop → count stays 4, `ovf_o`=0.
   - At count 0: push 0x12 + pop → count 1, `udf_o`=1, `data_o`=0x12.
4. **Wrap-around with non-power-of-2 depth.** With `DEPTH`=5, run 12 push/pop pairs with an alternating fill of 1..3 entries → FIFO order is preserved across pointer wraps at index 4→0.
5. **Reset mid-operation.** Fill to 2 entries, assert `rst_i` together with push → after the edge `count_o`=0, `data_o`=0, flags are at reset values, and the pushed data is discarded.
6. **Random soak.** Run 1000 cycles of random push/pop/`clr_err_i` against a queue model → `data_o`, `count_o` and all flags match the model every cycle.
